ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the opposite direction of the existing keyboard receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable. Drives the open-drain PS/2 clock and data lines through pull-low enables, and reports device ACK/NACK.
- Sits beside the PS/2 receiver in the top level on the same system clock; Tx_Busy_Out lets the receiver ignore line activity during a host transfer.

---
 rtl/ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the attached device. It drives the open-drain clock and
// data lines through pull-low enables and reports the device ACK (Tx_Done_Out) or a
// NACK/timeout (Tx_Error_Out).
// Optional build macro PS2_TX_RESEND_EN: when defined, a NACKed byte is re-sent up to
// two more times before an error is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  input  logic [7:0] Tx_Data_In,
  input  logic       Tx_Valid_In,
  output logic       Tx_Ready_Out,
  output logic       Tx_Busy_Out,
  output logic       Tx_Done_Out,
  output logic       Tx_Error_Out,
  input  logic       PS2_Clk_In,
  input  logic       PS2_Data_In,
  output logic       PS2_Clk_Low_Out,
  output logic       PS2_Data_Low_Out
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);

  // Odd parity over the command byte: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          clk_fall;

  logic [2:0]    state;
  logic [7:0]    tx_byte;
  logic          par;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          clk_low;
  logic          data_low;
  logic          ready;
  logic          busy;
  logic          done;
  logic          error;
  logic          active;
  logic          tmo_hit;
`ifdef PS2_TX_RESEND_EN
  logic [1:0]    retry_cnt;
`endif

  // The device drives the clock only in these phases, so only here can it time out.
  assign active  = (state == ST_REQ) || (state == ST_SEND) || (state == ST_WAIT_IDLE);
  assign tmo_hit = active && (tmo_cnt == TMO_LAST) && !clk_fall;

  // Two-stage synchronizers for the raw line levels; idle lines read high.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_Clk_In};
      data_sync <= {data_sync[0], PS2_Data_In};
    end
  end

  // Glitch filter on the clock: the level flips only after FILTER_LEN agreeing samples.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_filt <= clk_sync[1];
          flt_cnt  <= '0;
          clk_fall <= clk_filt;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  // Timeout counter: held at zero outside device-clocked phases, restarted by each fall.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      tmo_cnt <= '0;
    end else if (active && !clk_fall && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Transfer sequencer: state, bit/inhibit counters, line drives and status pulses.
  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      state     <= ST_IDLE;
      tx_byte   <= 8'h00;
      par       <= 1'b0;
      bit_cnt   <= 4'd0;
      inh_cnt   <= '0;
      clk_low   <= 1'b0;
      data_low  <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_cnt <= 2'd0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready    <= 1'b1;
          busy     <= 1'b0;
          clk_low  <= 1'b0;
          data_low <= 1'b0;
          if (Tx_Valid_In && ready) begin
            tx_byte   <= Tx_Data_In;
            par       <= odd_parity(Tx_Data_In);
            bit_cnt   <= 4'd0;
            inh_cnt   <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
            clk_low   <= 1'b1;
            state     <= ST_INHIBIT;
`ifdef PS2_TX_RESEND_EN
            retry_cnt <= 2'd0;
`endif
          end
        end

        ST_INHIBIT: begin
          clk_low <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            // Release the clock while still holding the start bit low.
            clk_low  <= 1'b0;
            data_low <= 1'b1;
            state    <= ST_REQ;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
            // Start bit goes out in the last inhibit cycle.
            if (inh_cnt == INH_START) begin
              data_low <= 1'b1;
            end else begin
              data_low <= 1'b0;
            end
          end
        end

        ST_REQ: begin
          if (tmo_hit) begin
            error    <= 1'b1;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            clk_low  <= 1'b0;
            data_low <= 1'b1;
            state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (tmo_hit) begin
            error    <= 1'b1;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            state    <= ST_IDLE;
          end else if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              data_low <= ~tx_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_low <= ~par;
            end else if (bit_cnt == 4'd9) begin
              data_low <= 1'b0;
            end else begin
              // Acknowledge clock: the device pulls data low to accept the byte.
              data_low <= 1'b0;
              if (!data_sync[1]) begin
                state <= ST_WAIT_IDLE;
              end else begin
`ifdef PS2_TX_RESEND_EN
                if (retry_cnt != 2'd2) begin
                  retry_cnt <= retry_cnt + 2'd1;
                  bit_cnt   <= 4'd0;
                  inh_cnt   <= '0;
                  clk_low   <= 1'b1;
                  state     <= ST_INHIBIT;
                end else begin
                  error <= 1'b1;
                  state <= ST_IDLE;
                end
`else
                error <= 1'b1;
                state <= ST_IDLE;
`endif
              end
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (tmo_hit) begin
            error    <= 1'b1;
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            state    <= ST_IDLE;
          end else if (clk_filt && data_sync[1]) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: begin
          clk_low  <= 1'b0;
          data_low <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign Tx_Ready_Out     = ready;
  assign Tx_Busy_Out      = busy;
  assign Tx_Done_Out      = done;
  assign Tx_Error_Out     = error;
  assign PS2_Clk_Low_Out  = clk_low;
  assign PS2_Data_Low_Out = data_low;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

`ifdef PS2_TX_RESEND_EN
  localparam int NACK_ATT = 3;
`else
  localparam int NACK_ATT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       clk_low, data_low;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, lag_bad = 0, busy_bad = 0;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_line  = ~(clk_low | dev_clk_low);
  assign ps2_data_line = ~(data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(2000),
    .FILTER_LEN(4)
  ) dut (
    .Master_Clock_In (clk),
    .Reset_In        (rst),
    .Tx_Data_In      (tx_data),
    .Tx_Valid_In     (tx_valid),
    .Tx_Ready_Out    (tx_ready),
    .Tx_Busy_Out     (tx_busy),
    .Tx_Done_Out     (tx_done),
    .Tx_Error_Out    (tx_error),
    .PS2_Clk_In      (ps2_clk_line),
    .PS2_Data_In     (ps2_data_line),
    .PS2_Clk_Low_Out (clk_low),
    .PS2_Data_Low_Out(data_low)
  );

  // Pulse counters and handshake-relationship monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) done_cnt++;
      if (tx_error) err_cnt++;
      if (tx_done && tx_error) both_cnt++;
      if (prev_pulse && tx_ready !== 1'b1) lag_bad++;
      if ((tx_done || tx_error) && tx_ready) lag_bad++;
      if (tx_busy !== ~tx_ready) busy_bad++;
      prev_pulse = tx_done | tx_error;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold valid until the handshake edge has passed.
  task automatic start_tx(input logic [7:0] b);
    int k;
    tx_data  = b;
    tx_valid = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", {31'b0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Count consecutive cycles with the clock line inhibited.
  task automatic count_inhibit(output int n);
    n = 0;
    while (clk_low === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Device model: waits for the request-to-send condition, reads the start bit,
  // then generates nfalls clock pulses (20 low / 20 high), sampling data on each
  // rising edge and optionally pulling data low during the 11th (ACK) pulse.
  task automatic dev_xfer(input int nfalls, input bit ack, output logic [10:0] bits);
    int k;
    bits = '0;
    k = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("req_seen", {31'b0, (k < 500)}, 32'd1);
    repeat (15) @(negedge clk);
    bits[0] = ps2_data_line;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) bits[i] = ps2_data_line;
      dev_data_low = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] bits;
    int n, d0, e0;

    rst = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_clk_low", {31'b0, clk_low}, 32'd0);
    check("rst_data_low", {31'b0, data_low}, 32'd0);
    check("rst_done", {31'b0, tx_done}, 32'd0);
    check("rst_error", {31'b0, tx_error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xED with ACK: frame = stop1 par1 ED start0 = 11'h7DA
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    count_inhibit(n);
    check("ed_inhibit_len", n, 32'd20);
    dev_xfer(11, 1'b1, bits);
    check("ed_frame", {21'b0, bits}, 32'h7DA);
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_err", err_cnt - e0, 32'd0);
    check("ed_ready", {31'b0, tx_ready}, 32'd1);

    // 0xF4 with ACK: frame = 1 0 F4 0 = 11'h5E8
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    dev_xfer(11, 1'b1, bits);
    check("f4_frame", {21'b0, bits}, 32'h5E8);
    check("f4_done", done_cnt - d0, 32'd1);
    check("f4_err", err_cnt - e0, 32'd0);

    // 0x55 NACKed: frame = 1 1 55 0 = 11'h6AA on every attempt
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h55);
    for (int a = 0; a < NACK_ATT; a++) begin
      dev_xfer(11, 1'b0, bits);
      check("nack_frame", {21'b0, bits}, 32'h6AA);
      check("nack_err", err_cnt - e0, (a == NACK_ATT - 1) ? 32'd1 : 32'd0);
    end
    check("nack_done", done_cnt - d0, 32'd0);
    check("nack_ready", {31'b0, tx_ready}, 32'd1);

    // Silent device: error exactly 2000 cycles after the clock is released
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h0F);
    count_inhibit(n);
    check("tmo_inhibit_len", n, 32'd20);
    n = 0;
    while (tx_error !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 32'd2000);
    check("tmo_clk_low", {31'b0, clk_low}, 32'd0);
    check("tmo_data_low", {31'b0, data_low}, 32'd0);
    @(negedge clk);
    check("tmo_ready", {31'b0, tx_ready}, 32'd1);
    check("tmo_err", err_cnt - e0, 32'd1);
    check("tmo_done", done_cnt - d0, 32'd0);

    // Reset during SEND after bit 4 (0x37 bit3 = 0, so data is pulled low)
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h37);
    dev_xfer(4, 1'b0, bits);
    check("mid_data_low", {31'b0, data_low}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_clk_low", {31'b0, clk_low}, 32'd0);
    check("mid_data_rel", {31'b0, data_low}, 32'd0);
    check("mid_ready", {31'b0, tx_ready}, 32'd1);
    check("mid_pulses", {30'b0, tx_done, tx_error}, 32'd0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_no_done", done_cnt - d0, 32'd0);
    check("mid_no_err", err_cnt - e0, 32'd0);
    start_tx(8'hF4);
    dev_xfer(11, 1'b1, bits);
    check("post_f4_frame", {21'b0, bits}, 32'h5E8);
    check("post_f4_done", done_cnt - d0, 32'd1);

    // 0xAA held valid while 0xED is in flight; frame for AA = 1 1 AA 0 = 11'h754
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    dev_xfer(11, 1'b1, bits);
    tx_valid = 1'b0;
    check("hold_ed_frame", {21'b0, bits}, 32'h7DA);
    check("hold_ed_done", done_cnt - d0, 32'd1);
    check("hold_aa_busy", {31'b0, tx_busy}, 32'd1);
    dev_xfer(11, 1'b1, bits);
    check("hold_aa_frame", {21'b0, bits}, 32'h754);
    check("hold_aa_done", done_cnt - d0, 32'd2);
    check("hold_err", err_cnt - e0, 32'd0);
    check("hold_ready", {31'b0, tx_ready}, 32'd1);

    check("done_err_overlap", both_cnt, 32'd0);
    check("ready_after_pulse", lag_bad, 32'd0);
    check("busy_not_ready", busy_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
